daq_frame_packer: RTL

//  Builds framed 32-bit DAQ test data and writes it into the 32-bit read FIFO (fifo_32x512) for /dev/xillybus_read_32.

---
 rtl/daq_frame_packer.sv | 117 +++++++++++
 1 files changed

// File: rtl/daq_frame_packer.sv
// Frame generator for the 32-bit read FIFO: header, counter payload, checksum trailer,
// paced by a clock-enable divider with hold-on-full back-pressure.
module daq_frame_packer #(
  parameter logic [7:0]  HEADER_TAG  = 8'hA5,
  parameter logic [7:0]  TRAILER_TAG = 8'h5A,
  parameter int unsigned DIV_WIDTH   = 8
) (
  input  logic                 bus_clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [7:0]           cfg_len,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 fifo_full,
  output logic [31:0]          fifo_din,
  output logic                 fifo_wr_en,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_l;
  logic [7:0]           len_l;
  logic [7:0]           pay_idx;
  logic [31:0]          data_cnt;
  logic [15:0]          checksum;
  logic                 pending;
  logic                 tick;
  logic [31:0]          word;

  always_comb begin
    // >= keeps the slot timing sane if a smaller divisor is latched while the count is high
    tick = (state != IDLE) && (div_cnt >= div_l);
    word = '0;
    case (state)
      HEADER:  word = {HEADER_TAG, frame_cnt, len_l};
      PAYLOAD: word = data_cnt;
      TRAILER: word = {TRAILER_TAG, 8'h00, checksum};
      default: word = '0;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state      <= IDLE;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
      data_cnt   <= '0;
      checksum   <= '0;
      div_cnt    <= '0;
      div_l      <= '0;
      len_l      <= '0;
      pay_idx    <= '0;
      pending    <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          pending  <= 1'b0;
          checksum <= '0;
          if (cfg_start) begin
            len_l <= cfg_len;
            div_l <= cfg_div;
            state <= HEADER;
            busy  <= 1'b1;
          end
        end
        default: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
          if (!fifo_full && (pending || tick)) begin
            // a fresh tick arriving with a held write becomes the next word's slot
            fifo_wr_en <= 1'b1;
            fifo_din   <= word;
            pending    <= pending && tick;
            case (state)
              HEADER: begin
                pay_idx <= '0;
                state   <= PAYLOAD;
              end
              PAYLOAD: begin
                data_cnt <= data_cnt + 32'd1;
                checksum <= checksum + data_cnt[15:0];
                pay_idx  <= pay_idx + 8'd1;
                if (pay_idx == len_l - 8'd1) state <= TRAILER;
              end
              TRAILER: begin
                frame_cnt <= frame_cnt + 16'd1;
                checksum  <= '0;
                if (cfg_start) begin
                  state <= HEADER;
                  len_l <= cfg_len;
                  div_l <= cfg_div;
                end else begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  pending <= 1'b0;
                end
              end
              default: ;
            endcase
          end else if (tick) begin
            if (pending) overflow <= 1'b1;
            else         pending  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
